// File: rtl/snes_pad_if.sv
// Pad-reader signal bundle: the poll controls and serial pad pins, plus the parallel button word.
// valid/changed are one-cycle strobes with no ready: the consumer must take buttons in the valid cycle.
interface snes_pad_if;
  logic        poll_en;
  logic        poll_now;
  logic        pad_data;
  logic        pad_latch;
  logic        pad_clk;
  logic [15:0] buttons;
  logic        valid;
  logic        changed;
  logic        busy;

  modport master (
    input  poll_en, poll_now, pad_data,
    output pad_latch, pad_clk, buttons, valid, changed, busy
  );

  modport slave (
    output poll_en, poll_now, pad_data,
    input  pad_latch, pad_clk, buttons, valid, changed, busy
  );
endinterface

// File: rtl/snes_pad_reader.sv
// Polls an SNES-style controller (latch + 16 clocked bits, active low) and presents the
// button word in parallel with a valid strobe and a changed flag.
module snes_pad_reader #(
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300,
  parameter int POLL_CYCLES  = 833333
) (
  input  logic       clk,
  input  logic       reset,
  snes_pad_if.master pad,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    HI      = 3'd2,
    LO      = 3'd3,
    LO_LAST = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int CMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int PW   = $clog2(POLL_CYCLES) + 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [3:0]    idx_q, idx_d;
  logic [15:0]   shift_q, shift_d;
  logic [15:0]   buttons_q, buttons_d;
  logic          valid_q, valid_d;
  logic          changed_q, changed_d;
  logic          latch_q, latch_d;
  logic          pclk_q, pclk_d;
  logic          busy_q, busy_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;

  logic half_last;
  assign half_last = (cnt_q == CW'(HALF_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    changed_d = 1'b0;
    poll_d    = (poll_q == PW'(POLL_CYCLES - 1)) ? '0 : poll_q + 1'b1;
    sync1_d   = pad.pad_data;
    sync2_d   = sync1_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pad.poll_now || (pad.poll_en && poll_q == PW'(POLL_CYCLES - 1))) begin
          state_d = LATCH;
          poll_d  = '0;
        end
      end
      LATCH: begin
        if (cnt_q == CW'(LATCH_CYCLES - 1)) begin
          state_d = HI;
          cnt_d   = '0;
          idx_d   = 4'd15;
        end
      end
      HI: begin
        // Sample at the end of the high phase so the synchronised bit has settled.
        if (half_last) begin
          shift_d[idx_q] = sync2_q;
          cnt_d          = '0;
          if (idx_q == 4'd0) begin
            state_d = LO_LAST;
          end else begin
            idx_d   = idx_q - 4'd1;
            state_d = LO;
          end
        end
      end
      LO: begin
        if (half_last) begin
          state_d = HI;
          cnt_d   = '0;
        end
      end
      LO_LAST: begin
        if (half_last) begin
          state_d   = DONE;
          cnt_d     = '0;
          buttons_d = shift_q;
          changed_d = (shift_q != buttons_q);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    latch_d = (state_d == LATCH);
    pclk_d  = !((state_d == LO) || (state_d == LO_LAST));
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      poll_q    <= '0;
      idx_q     <= 4'd15;
      shift_q   <= 16'hFFFF;
      buttons_q <= 16'hFFFF;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b1;
      busy_q    <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      poll_q    <= poll_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      latch_q   <= latch_d;
      pclk_q    <= pclk_d;
      busy_q    <= busy_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
    end
  end

  assign pad.pad_latch = latch_q;
  assign pad.pad_clk   = pclk_q;
  assign pad.buttons   = buttons_q;
  assign pad.valid     = valid_q;
  assign pad.changed   = changed_q;
  assign pad.busy      = busy_q;
  assign state_dbg     = state_q;
endmodule
